// File: rtl/core_message_arbiter.sv
// Round-robin N-core message arbiter and dispatch sequencer: boots the first process, then feeds
// granted core messages to the message handler. Define MSG_ARB_STATS_EN for per-core grant counters.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 16
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef CORE_MESSAGE_NONE
`define CORE_MESSAGE_NONE 4'd0
`endif
`ifndef CORE_MESSAGE_START_PROCESS
`define CORE_MESSAGE_START_PROCESS 4'd1
`endif

module core_msg_req_lane (
  input  logic [3:0] msg,
  input  logic       active,
  output logic       req
);
  assign req = (msg != `CORE_MESSAGE_NONE) && active;
endmodule

`ifdef MSG_ARB_STATS_EN
module msg_arb_grant_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
  end
endmodule
`endif

module core_message_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int SRC_BITS  = $clog2(NUM_CORES),
  parameter int ADDR_BITS = `ADDRESS_BITS,
  parameter int DATA_BITS = `DATA_BITS,
  parameter int JUMP_BITS = 9,
  parameter int BOOT_CORE = NUM_CORES - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES*4-1:0]         coreMessage,
  input  logic [NUM_CORES*ADDR_BITS-1:0] coreMessageChannel,
  input  logic [NUM_CORES*DATA_BITS-1:0] coreMessageMessage,
  input  logic [NUM_CORES*ADDR_BITS-1:0] coreMessageNumWords,
  input  logic [NUM_CORES*JUMP_BITS-1:0] coreMessageJumpDestination,
  input  logic [NUM_CORES-1:0]           coreHadMessageInAlt,
  input  logic [NUM_CORES-1:0]           coreActive,
  input  logic                           handlerFinished,
  input  logic                           canHalt,
  output logic                           handlerEnabled,
  output logic [3:0]                     outMessage,
  output logic [ADDR_BITS-1:0]           outChannel,
  output logic [DATA_BITS-1:0]           outMessageMessage,
  output logic [ADDR_BITS-1:0]           outNumWords,
  output logic [JUMP_BITS-1:0]           outJumpDestination,
  output logic                           outHadMessageInAlt,
  output logic [SRC_BITS-1:0]            outSource,
  output logic                           finished
`ifdef MSG_ARB_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0]        grantCount
`endif
);

  typedef struct packed {
    logic [3:0]           code;
    logic [ADDR_BITS-1:0] channel;
    logic [DATA_BITS-1:0] payload;
    logic [ADDR_BITS-1:0] numWords;
    logic [JUMP_BITS-1:0] jump;
    logic                 alt;
  } msg_t;

  typedef enum logic [1:0] {INIT, BOOT, HANDLE, EXECUTE} state_t;

  state_t                              state;
  msg_t                                held;
  logic [SRC_BITS-1:0]                 heldSrc;
  logic [SRC_BITS-1:0]                 rrPtr;

  logic [NUM_CORES-1:0][3:0]           codeArr;
  logic [NUM_CORES-1:0][ADDR_BITS-1:0] chanArr;
  logic [NUM_CORES-1:0][DATA_BITS-1:0] dataArr;
  logic [NUM_CORES-1:0][ADDR_BITS-1:0] wordsArr;
  logic [NUM_CORES-1:0][JUMP_BITS-1:0] jumpArr;
  logic [NUM_CORES-1:0]                req;

  logic                                grantValid;
  logic [SRC_BITS-1:0]                 grantIdx;
  logic [SRC_BITS-1:0]                 nextPtr;
  msg_t                                grantMsg;
  msg_t                                bootMsg;

  assign codeArr  = coreMessage;
  assign chanArr  = coreMessageChannel;
  assign dataArr  = coreMessageMessage;
  assign wordsArr = coreMessageNumWords;
  assign jumpArr  = coreMessageJumpDestination;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    core_msg_req_lane u_lane (
      .msg    (codeArr[i]),
      .active (coreActive[i]),
      .req    (req[i])
    );
  end

  // Scan from the farthest slot back toward rrPtr so the nearest requester wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rrPtr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (req[idx]) begin
        grantValid = 1'b1;
        grantIdx   = SRC_BITS'(idx);
      end
    end
  end

  assign nextPtr = (grantIdx == SRC_BITS'(NUM_CORES - 1)) ? '0 : grantIdx + 1'b1;

  assign grantMsg = '{code:     codeArr[grantIdx],
                      channel:  chanArr[grantIdx],
                      payload:  dataArr[grantIdx],
                      numWords: wordsArr[grantIdx],
                      jump:     jumpArr[grantIdx],
                      alt:      coreHadMessageInAlt[grantIdx]};

  assign bootMsg = '{code: `CORE_MESSAGE_START_PROCESS, channel: '0, payload: '0,
                     numWords: '0, jump: '0, alt: 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      finished <= 1'b0;
      rrPtr    <= '0;
      heldSrc  <= '0;
      held     <= '{code: `CORE_MESSAGE_NONE, channel: '0, payload: '0,
                    numWords: '0, jump: '0, alt: 1'b0};
    end else begin
      case (state)
        INIT: state <= BOOT;
        BOOT: begin
          held    <= bootMsg;
          heldSrc <= SRC_BITS'(BOOT_CORE);
          state   <= HANDLE;
        end
        HANDLE: begin
          if (handlerFinished) begin
            finished <= canHalt;
            state    <= EXECUTE;
          end
        end
        EXECUTE: begin
          finished <= canHalt;
          if (grantValid) begin
            held    <= grantMsg;
            heldSrc <= grantIdx;
            rrPtr   <= nextPtr;
            state   <= HANDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign handlerEnabled     = (state == HANDLE) && !handlerFinished;
  assign outMessage         = held.code;
  assign outChannel         = held.channel;
  assign outMessageMessage  = held.payload;
  assign outNumWords        = held.numWords;
  assign outJumpDestination = held.jump;
  assign outHadMessageInAlt = held.alt;
  assign outSource          = heldSrc;

`ifdef MSG_ARB_STATS_EN
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_stat
    msg_arb_grant_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   ((state == EXECUTE) && grantValid && (grantIdx == SRC_BITS'(i))),
      .count (grantCount[i*16 +: 16])
    );
  end
`endif

endmodule

// File: doc/core_message_arbiter.md
# core_message_arbiter

Parametrised N-core message arbiter and dispatch sequencer for the stannel processor top level. It boots the first process, then collects outbound core messages from `NUM_CORES` cores using true round-robin arbitration. It latches the granted message into a single holding register and drives the processor message handler through an enable/finished handshake. It also reports whole-processor completion from the handler's `canHalt` indication.

## Interface
- `NUM_CORES`, 4: number of cores arbitrated; ≥2.
- `SRC_BITS`, `$clog2(NUM_CORES)`: width of the core index.
- `ADDR_BITS`, `` `ADDRESS_BITS ``: channel/word-count width.
- `DATA_BITS`, `` `DATA_BITS ``: message payload width.
- `JUMP_BITS`, 9: jump destination width.
- `BOOT_CORE`, `NUM_CORES-1`: core index tagged as source of the boot START_PROCESS message.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `coreMessage` in `NUM_CORES*4`: per-core message code, core i at `[4i+3:4i]`; `` `CORE_MESSAGE_NONE `` = no request.
- `coreMessageChannel` in `NUM_CORES*ADDR_BITS`: per-core channel.
- `coreMessageMessage` in `NUM_CORES*DATA_BITS`: per-core payload.
- `coreMessageNumWords` in `NUM_CORES*ADDR_BITS`: per-core word count.
- `coreMessageJumpDestination` in `NUM_CORES*JUMP_BITS`: per-core jump target.
- `coreHadMessageInAlt` in `NUM_CORES`: per-core alt flag.
- `coreActive` in `NUM_CORES`: core holds a live process; an inactive core is never granted.
- `handlerFinished` in 1: handler has completed the latched message.
- `canHalt` in 1: handler reports no runnable/blocked work remains.
- `handlerEnabled` out 1: handler may process the latched message.
- `outMessage` out 4, `outChannel` out `ADDR_BITS`, `outMessageMessage` out `DATA_BITS`, `outNumWords` out `ADDR_BITS`, `outJumpDestination` out `JUMP_BITS`, `outHadMessageInAlt` out 1, `outSource` out `SRC_BITS`: latched message fields (registered).
- `finished` out 1: registered halt indication.

## Operation
- States: INIT → BOOT → HANDLE ⇄ EXECUTE. Reset forces INIT.
- INIT: one idle cycle, then BOOT.
- BOOT: latches `` `CORE_MESSAGE_START_PROCESS ``, `outNumWords`=0, `outJumpDestination`=0, `outSource`=`BOOT_CORE`, and sets alt/channel/payload to 0. It then goes to HANDLE.
- HANDLE: `handlerEnabled` = `~handlerFinished` (combinational). On `handlerFinished`=1 it goes to EXECUTE, and next-`finished` = `canHalt`.
- EXECUTE: next-`finished` = `canHalt`.
  - Request i = `coreMessage[i]` ≠ NONE && `coreActive[i]`.
  - Search starts at pointer `rrPtr` and runs i = rrPtr, rrPtr+1, … mod `NUM_CORES`; the first request found is granted.
  - On grant: all fields of core i are latched, `outSource`=i, `rrPtr` ← (i+1) mod `NUM_CORES`, and the state goes to HANDLE.
  - No request: stay in EXECUTE and leave the latched fields unchanged.
- Wrap: a grant to core `NUM_CORES-1` sets `rrPtr`=0.
- When `canHalt` and a request occur together in EXECUTE, both `finished` and the grant proceed.
- Latched fields change only in BOOT or on a grant.

## Timing
- Reset values: state INIT, `finished`=0, `rrPtr`=0, `outMessage`=NONE, all other out fields 0, `handlerEnabled`=0.
- Boot: reset deassert at edge 0 → BOOT after edge 1 → HANDLE with the boot message latched after edge 2.
- Grant latency: a request is sampled in an EXECUTE cycle. The fields are latched and the state is HANDLE after the next edge, with `handlerEnabled` high in that same cycle.
- Handshake: `handlerEnabled` drops in the cycle `handlerFinished` is high. EXECUTE is entered on the following edge.
- Minimum service period is 2 cycles per message (HANDLE + EXECUTE).
- `finished` lags `canHalt` by one cycle.
- Reset asserted mid-operation has priority over all transitions. It discards the latched message and restarts at INIT.

## Configuration
- `MSG_ARB_STATS_EN` defined:
  - Adds output `grantCount` of width `NUM_CORES*16`, with a 16-bit counter per core.
  - A counter increments on each EXECUTE grant to its core and saturates at 16'hFFFF.
  - The boot message is not counted. Counters are cleared by reset.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

## Test plan
- Boot: release reset with `handlerFinished`=0 → edge 2: `outMessage`=START_PROCESS, `outSource`=3, `outJumpDestination`=0, `handlerEnabled`=1; hold 5 cycles → enable stays 1; pulse `handlerFinished` → EXECUTE.
- Round-robin: all 4 cores active and requesting continuously, handler finishing in 1 cycle → grants 0,1,2,3,0,… and `rrPtr` wraps to 0 after core 3.
- Skip: `rrPtr`=1, core 1 requesting but `coreActive[1]`=0, core 3 requesting → core 3 granted, `rrPtr`=0; core 1 never granted.
- Idle/halt: no requests, `canHalt`=1 in EXECUTE → `finished`=1 one cycle later, fields unchanged; `canHalt`=0 → `finished`=0 next cycle.
- Simultaneous: `canHalt`=1 and core 2 requesting `channel`=16'h0042 → `finished`=1 and `outChannel`=16'h0042, `outSource`=2 on the same edge.
- Reset mid-HANDLE with core 1 latched → next cycle `outMessage`=NONE, `handlerEnabled`=0, `rrPtr`=0, and the boot sequence repeats. With `MSG_ARB_STATS_EN`, counters read 0.
